accel_reg_responder: RTL and testbench
======================================

# accel_reg_responder

Memory-mapped register responder that sits between the SoC interconnect CPU port and one accelerator engine, such as FFT at 0x7000 or crypto at 0x6000. It answers the `cpu_valid`/`cpu_write`/`cpu_addr`/`cpu_wdata` request with a registered `cpu_ready`/`cpu_rdata` response. It owns the CTRL, STATUS, IN_BASE and OUT_BASE registers and sequences the engine through start, busy and done. A watchdog aborts a hung engine, and a level interrupt reports completion.

## Interface
Parameters:
- `ADDR_W`, 19: bus address width.
- `DATA_W`, 19: bus data width and base-register width.
- `BASE_ADDR`, 19'h7000: start of the 16-byte register window; must be 16-aligned.
- `TIMEOUT_CYC`, 4096: maximum number of BUSY cycles before abort; must be ≥2.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_valid`  in  1  request valid; the initiator holds it until it sees `cpu_ready`.
- `cpu_write`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_ready`  out  1  one-cycle response strobe.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ready`=1, 0 otherwise.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_in_base`, `eng_out_base`  out  DATA_W  base addresses, frozen while the block is busy.
- `eng_done`  in  1  engine completion pulse.
- `eng_abort`  out  1  one-cycle abort pulse on watchdog expiry.
- `irq`  out  1  level interrupt.

## Operation
Register map (offset from BASE_ADDR):
- **0x0 CTRL**
  - bit0 START: write-1 starts the engine; always reads 0.
  - bit1 IRQ_EN: read/write.
- **0x4 STATUS**
  - bit0 DONE: sticky, W1C.
  - bit1 BUSY: read-only.
  - bit2 TIMEOUT: sticky, W1C.
  - bit3 ERR: sticky, W1C.
- **0x8 IN_BASE**, **0xC OUT_BASE**: read/write, full DATA_W.

Address decode and acceptance:
- The block is selected when `cpu_addr[ADDR_W-1:4]` == `BASE_ADDR[ADDR_W-1:4]`.
- An address outside the window gets no response; another responder owns it.
- A selected address with `cpu_addr[1:0]`≠0 reads 0, and a write to it is ignored. It still gets `cpu_ready`.
- A request is accepted when `cpu_valid` and select are high and no response is pending.

Engine FSM, states IDLE and BUSY:
- **IDLE → BUSY** on an accepted CTRL write with bit0=1.
  - `eng_start` pulses.
  - `eng_in_base`/`eng_out_base` capture IN_BASE/OUT_BASE.
  - DONE and TIMEOUT clear.
  - The watchdog counter loads 0.
- **BUSY → IDLE** on `eng_done`: DONE is set.
- **BUSY → IDLE** when the watchdog count reaches TIMEOUT_CYC-1 without `eng_done`: `eng_abort` pulses and TIMEOUT is set.
- While BUSY, any write to CTRL with START=1, to IN_BASE or to OUT_BASE is dropped and sets ERR. The IRQ_EN bit of a CTRL write is still applied.
- `eng_done` in IDLE is ignored.

`irq` = IRQ_EN & (DONE | TIMEOUT | ERR).

## Timing
- Response latency:
  - Request sampled at edge N → `cpu_ready`=1 and `cpu_rdata` valid for exactly the cycle after N.
  - No new request is accepted while `cpu_ready`=1, so maximum throughput is one access per 2 cycles.
- Write side effects, including `eng_start`, take effect in the same cycle as `cpu_ready`.
- A read of STATUS returns the value from before any same-cycle event.
- `eng_done` sampled at edge M → BUSY=0 and DONE=1 from M+1.
- Simultaneous events:
  - `eng_done` and watchdog expiry in the same cycle: done wins, with no abort and no TIMEOUT.
  - W1C of DONE in the same cycle a hardware set of DONE: the set wins.
  - START write in the same cycle as `eng_done`: the block is still BUSY at that edge, so ERR is set and there is no restart.
- Watchdog: the count saturates and never wraps; it is held at 0 in IDLE.
- Reset values:
  - All outputs 0.
  - All registers 0, FSM in IDLE, pending response cleared.
- Reset mid-transaction discards the response. Reset mid-BUSY returns to IDLE with no `eng_abort` pulse; the engine shares `rst`.

## Structure
- Package `accel_reg_pkg`:
  - Offset constants `CTRL_OFF`, `STATUS_OFF`, `IN_BASE_OFF`, `OUT_BASE_OFF`.
  - Bit-index constants for START, IRQ_EN, DONE, BUSY, TIMEOUT, ERR.
  - FSM enum `eng_state_t {IDLE, BUSY}`.
- Sub-module `accel_watchdog`: a saturating counter with `clear`, `en` and `expired` signals, parameterised by TIMEOUT_CYC.
- The bus responder and register file stay in the top module.

## Test plan
- **Register round-trip.** Write IN_BASE=100 and OUT_BASE=200, then read them back.
  - Reads return 100 and 200.
  - Each `cpu_ready` comes exactly 1 cycle after acceptance.
  - A read of CTRL returns 0.
- **Start and done.**
  - Stimulus: with bases set, write CTRL=0x3, then pulse `eng_done` 10 cycles later.
  - Required: `eng_start` is a single pulse, `eng_in_base`=100 and `eng_out_base`=200.
  - STATUS reads 0x2 during the run and 0x1 after done, and `irq`=1.
  - Writing STATUS=0x1 drops `irq` and reads back 0x0.
- **Busy lockout.**
  - Stimulus: while BUSY, write IN_BASE=555 and write CTRL=0x1.
  - Required: no `eng_start`, IN_BASE still 100, `eng_in_base` unchanged, STATUS bit3=1.
- **Watchdog.**
  - Stimulus: TIMEOUT_CYC=16, start, and never assert `eng_done`.
  - Required: `eng_abort` pulses 16 cycles after `eng_start`, then STATUS=0x4.
  - Done at the expiry cycle instead gives STATUS=0x1 and no abort.
- **Decode.**
  - Access 0x6000 with BASE_ADDR=0x7000: no `cpu_ready` for 20 cycles.
  - Access 0x7002: `cpu_ready` with `cpu_rdata`=0, and a write to it has no effect.
- **Reset mid-BUSY.** Assert `rst` during BUSY.
  - All outputs go to 0 immediately, with no `eng_abort`.
  - After release, STATUS reads 0.

Source files
------------

// File: rtl/accel_reg_pkg.sv
// Package for the accelerator register responder.
// Holds the register offsets inside the 16-byte window, the bit positions
// of the CTRL and STATUS fields, and the engine sequencing state type.
package accel_reg_pkg;

  // Register offsets, compared against cpu_addr[3:0].
  localparam logic [3:0] CTRL_OFF     = 4'h0;
  localparam logic [3:0] STATUS_OFF   = 4'h4;
  localparam logic [3:0] IN_BASE_OFF  = 4'h8;
  localparam logic [3:0] OUT_BASE_OFF = 4'hC;

  // CTRL bit positions.
  localparam int START_BIT  = 0;
  localparam int IRQ_EN_BIT = 1;

  // STATUS bit positions.
  localparam int DONE_BIT    = 0;
  localparam int BUSY_BIT    = 1;
  localparam int TIMEOUT_BIT = 2;
  localparam int ERR_BIT     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } eng_state_t;

endpackage

// File: rtl/accel_watchdog.sv
// Saturating watchdog counter for the engine run.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - forces the count to 0 (held while the engine is idle)
//   en        - counts one per cycle while the engine is busy
//   expired   - count has reached TIMEOUT_CYC-1 while enabled
module accel_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      // Stops at LAST instead of wrapping back to 0.
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/accel_reg_responder.sv
// Memory-mapped register responder for one accelerator engine.
// Decodes a 16-byte window at BASE_ADDR, answers each accepted request with
// a one-cycle registered cpu_ready/cpu_rdata, owns CTRL/STATUS/IN_BASE/
// OUT_BASE, and sequences the engine through start, busy and done with a
// watchdog abort.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   cpu_valid/write/addr/wdata      - request from the interconnect
//   cpu_ready, cpu_rdata            - registered response strobe and data
//   eng_start, eng_abort            - one-cycle pulses to the engine
//   eng_in_base, eng_out_base       - bases frozen for the current run
//   eng_done                        - completion pulse from the engine
//   irq                             - level interrupt
module accel_reg_responder
  import accel_reg_pkg::*;
#(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 19,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 19'h7000,
  parameter int                TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_in_base,
  output logic [DATA_W-1:0] eng_out_base,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic              irq
);

  eng_state_t        state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] in_base_q, in_base_d;
  logic [DATA_W-1:0] out_base_q, out_base_d;
  logic [DATA_W-1:0] eng_in_base_q, eng_in_base_d;
  logic [DATA_W-1:0] eng_out_base_q, eng_out_base_d;
  logic              eng_start_q, eng_start_d;
  logic              eng_abort_q, eng_abort_d;

  logic              sel, aligned, accept, wr_acc, busy, wd_expired;
  logic              wr_ctrl, wr_status, wr_in, wr_out, lock_err;
  logic [3:0]        off;
  logic [DATA_W-1:0] rd_val;

  // Decode: the window is the upper address bits; only word offsets map.
  assign off     = cpu_addr[3:0];
  assign sel     = (cpu_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign aligned = (off[1:0] == 2'b00);
  // A pending response blocks acceptance, giving one access per 2 cycles.
  assign accept  = cpu_valid && sel && !ready_q;
  assign wr_acc  = accept && cpu_write && aligned;
  assign busy    = (state_q == BUSY);

  assign wr_ctrl   = wr_acc && (off == CTRL_OFF);
  assign wr_status = wr_acc && (off == STATUS_OFF);
  assign wr_in     = wr_acc && (off == IN_BASE_OFF);
  assign wr_out    = wr_acc && (off == OUT_BASE_OFF);

  // Writes that would disturb a running engine are dropped and flagged.
  assign lock_err = busy && ((wr_ctrl && cpu_wdata[START_BIT]) || wr_in || wr_out);

  accel_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .en      (busy),
    .expired (wd_expired)
  );

  // Read mux sees register values before any same-edge update.
  // NOTE: every signal driven from always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    rd_val = '0;
    if (aligned) begin
      case (off)
        CTRL_OFF:     rd_val[IRQ_EN_BIT] = irq_en_q;
        STATUS_OFF: begin
          rd_val[DONE_BIT]    = done_q;
          rd_val[BUSY_BIT]    = busy;
          rd_val[TIMEOUT_BIT] = timeout_q;
          rd_val[ERR_BIT]     = err_q;
        end
        IN_BASE_OFF:  rd_val = in_base_q;
        OUT_BASE_OFF: rd_val = out_base_q;
        default:      rd_val = '0;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    ready_d        = accept;
    rdata_d        = (accept && !cpu_write) ? rd_val : '0;
    irq_en_d       = irq_en_q;
    done_d         = done_q;
    timeout_d      = timeout_q;
    err_d          = err_q;
    in_base_d      = in_base_q;
    out_base_d     = out_base_q;
    eng_in_base_d  = eng_in_base_q;
    eng_out_base_d = eng_out_base_q;
    eng_start_d    = 1'b0;
    eng_abort_d    = 1'b0;

    // IRQ_EN is applied even when START is rejected.
    if (wr_ctrl)         irq_en_d   = cpu_wdata[IRQ_EN_BIT];
    if (wr_in && !busy)  in_base_d  = cpu_wdata;
    if (wr_out && !busy) out_base_d = cpu_wdata;

    // W1C first; hardware sets below override a same-cycle clear.
    if (wr_status) begin
      if (cpu_wdata[DONE_BIT])    done_d    = 1'b0;
      if (cpu_wdata[TIMEOUT_BIT]) timeout_d = 1'b0;
      if (cpu_wdata[ERR_BIT])     err_d     = 1'b0;
    end
    if (lock_err) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wr_ctrl && cpu_wdata[START_BIT]) begin
          state_d        = BUSY;
          eng_start_d    = 1'b1;
          eng_in_base_d  = in_base_q;
          eng_out_base_d = out_base_q;
          done_d         = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      BUSY: begin
        // Completion beats a watchdog expiry on the same edge.
        if (eng_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wd_expired) begin
          state_d     = IDLE;
          eng_abort_d = 1'b1;
          timeout_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: there are no memories here, so every flop is reset; a reset
  // mid-transaction discards the pending response and any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ready_q        <= 1'b0;
      rdata_q        <= '0;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      err_q          <= 1'b0;
      in_base_q      <= '0;
      out_base_q     <= '0;
      eng_in_base_q  <= '0;
      eng_out_base_q <= '0;
      eng_start_q    <= 1'b0;
      eng_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      rdata_q        <= rdata_d;
      irq_en_q       <= irq_en_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      err_q          <= err_d;
      in_base_q      <= in_base_d;
      out_base_q     <= out_base_d;
      eng_in_base_q  <= eng_in_base_d;
      eng_out_base_q <= eng_out_base_d;
      eng_start_q    <= eng_start_d;
      eng_abort_q    <= eng_abort_d;
    end
  end

  assign cpu_ready    = ready_q;
  assign cpu_rdata    = rdata_q;
  assign eng_start    = eng_start_q;
  assign eng_abort    = eng_abort_q;
  assign eng_in_base  = eng_in_base_q;
  assign eng_out_base = eng_out_base_q;
  assign irq          = irq_en_q && (done_q || timeout_q || err_q);

endmodule

// File: tb/tb_accel_reg_responder.sv
// Scoreboard bench for accel_reg_responder: the stimulus pushes the expected
// response of each request into a queue, and a monitor pops and compares
// whenever the DUT raises cpu_ready.
module tb_accel_reg_responder;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 19;
  localparam logic [ADDR_W-1:0] BASE = 19'h7000;
  localparam int TMO = 16;

  typedef struct {
    logic              is_rd;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_valid, cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              eng_start, eng_abort, eng_done, irq;
  logic [DATA_W-1:0] eng_in_base, eng_out_base;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_start  = 0;
  int   n_abort  = 0;
  exp_t exp_q[$];

  accel_reg_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .eng_start(eng_start), .eng_in_base(eng_in_base), .eng_out_base(eng_out_base),
    .eng_done(eng_done), .eng_abort(eng_abort), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count engine pulses and score every response.
  always @(negedge clk) begin
    if (eng_start) n_start++;
    if (eng_abort) n_abort++;
    if (cpu_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ready_latency", 32'(cyc), 32'(e.cyc));
        if (e.is_rd) check("rdata", 32'(cpu_rdata), 32'(e.data));
      end
    end
  end

  // One access: present at a falling edge, accepted at the next rising edge,
  // dropped at the falling edge where cpu_ready is visible.
  task automatic bus(input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
    exp_t e;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = wr ? d : '0;
    e.is_rd = !wr; e.data = exp_rd; e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus(1'b1, a, d, '0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_rd);
    bus(1'b0, a, '0, exp_rd);
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(cpu_ready), 32'd0);
    check({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_start"}, 32'(eng_start), 32'd0);
    check({tag, "_abort"}, 32'(eng_abort), 32'd0);
    check({tag, "_inbase"}, 32'(eng_in_base), 32'd0);
    check({tag, "_outbase"}, 32'(eng_out_base), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, a0, t_start, t_abort;
    logic seen;
    rst = 1'b1; cpu_valid = 1'b0; cpu_write = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; eng_done = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Register round-trip.
    wr(BASE + 19'h8, 19'd100);
    wr(BASE + 19'hC, 19'd200);
    rd(BASE + 19'h8, 19'd100);
    rd(BASE + 19'hC, 19'd200);
    rd(BASE + 19'h0, 19'd0);

    // Start and done.
    s0 = n_start;
    wr(BASE + 19'h0, 19'h3);
    check("start_in_base", 32'(eng_in_base), 32'd100);
    check("start_out_base", 32'(eng_out_base), 32'd200);
    rd(BASE + 19'h4, 19'h2);
    repeat (7) @(negedge clk);
    pulse_done();
    check("start_pulses", 32'(n_start - s0), 32'd1);
    rd(BASE + 19'h4, 19'h1);
    check("irq_after_done", 32'(irq), 32'd1);
    rd(BASE + 19'h0, 19'h2);
    wr(BASE + 19'h4, 19'h1);
    check("irq_after_w1c", 32'(irq), 32'd0);
    rd(BASE + 19'h4, 19'h0);

    // Busy lockout.
    s0 = n_start;
    wr(BASE + 19'h0, 19'h3);
    wr(BASE + 19'h8, 19'd555);
    wr(BASE + 19'h0, 19'h1);
    check("lockout_starts", 32'(n_start - s0), 32'd1);
    rd(BASE + 19'h4, 19'hA);
    rd(BASE + 19'h8, 19'd100);
    check("lockout_eng_in_base", 32'(eng_in_base), 32'd100);
    pulse_done();
    rd(BASE + 19'h4, 19'h9);
    wr(BASE + 19'h4, 19'h9);
    rd(BASE + 19'h4, 19'h0);

    // Watchdog expiry.
    a0 = n_abort;
    wr(BASE + 19'h0, 19'h3);
    t_start = cyc;
    t_abort = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (eng_abort && t_abort < 0) t_abort = cyc;
    end
    check("abort_delay", 32'(t_abort - t_start), 32'(TMO));
    check("abort_pulses", 32'(n_abort - a0), 32'd1);
    rd(BASE + 19'h4, 19'h4);
    check("irq_after_timeout", 32'(irq), 32'd1);
    wr(BASE + 19'h4, 19'h4);

    // Done on the expiry edge wins.
    a0 = n_abort;
    wr(BASE + 19'h0, 19'h3);
    repeat (TMO - 1) @(negedge clk);
    pulse_done();
    repeat (3) @(negedge clk);
    check("done_at_expiry_abort", 32'(n_abort - a0), 32'd0);
    rd(BASE + 19'h4, 19'h1);
    wr(BASE + 19'h4, 19'h1);

    // Decode: foreign window never answered.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 19'h6000;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ready) seen = 1'b1;
    end
    cpu_valid = 1'b0;
    check("foreign_no_ready", 32'(seen), 32'd0);

    // Misaligned addresses answer with 0 and ignore writes.
    s0 = n_start;
    rd(BASE + 19'h2, 19'd0);
    wr(BASE + 19'h2, 19'h1);
    wr(BASE + 19'hA, 19'h7);
    rd(BASE + 19'h8, 19'd100);
    rd(BASE + 19'h0, 19'h2);
    check("misaligned_no_start", 32'(n_start - s0), 32'd0);

    // Reset in the middle of a run.
    a0 = n_abort;
    wr(BASE + 19'h0, 19'h3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("midrst_no_abort", 32'(n_abort - a0), 32'd0);
    rd(BASE + 19'h4, 19'h0);
    rd(BASE + 19'h8, 19'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
